// File: rtl/cond_status_unit.sv
// cond_status_unit: NZCV status register plus a per-lane ARM condition-code evaluator
// feeding a one-entry valid/ready output stage.
//
// Parameters:
//   LANES  - condition codes evaluated per transfer (1..8)
//   BYPASS - when nonzero, a status write in the same cycle feeds the evaluation
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   sr_wr_en, sr_wr_data  - load {N,Z,C,V} into the status register
//   cond_valid, cond,     - input handshake; lane i code is cond[4i+3:4i]
//   cond_ready
//   pass_valid, pass,     - output handshake; pass[i] is lane i's result
//   pass_ready
//   status                - registered NZCV
//   pass_cnt, fail_cnt    - saturating lane pass/fail counters (COND_STATS_EN only)
//
// Optional feature macro: COND_STATS_EN adds the pass_cnt/fail_cnt outputs and counters.

`timescale 1ns / 1ps

module cond_status_unit #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sr_wr_en,
    input  logic [3:0]         sr_wr_data,
    input  logic               cond_valid,
    input  logic [4*LANES-1:0] cond,
    output logic               cond_ready,
    output logic               pass_valid,
    output logic [LANES-1:0]   pass,
    input  logic               pass_ready,
    output logic [3:0]         status
`ifdef COND_STATS_EN
    ,
    output logic [15:0]        pass_cnt,
    output logic [15:0]        fail_cnt
`endif
);

    // Codes pair up as (test, inverse) on bit 0; 111x is AL/NV.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        unique case (code[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    logic [3:0]       status_q;
    logic             pass_valid_q;
    logic [LANES-1:0] pass_q;
    logic [3:0]       flags;
    logic [LANES-1:0] pass_next;
    logic             accept;

    always_comb begin
        flags = status_q;
        if (BYPASS != 0 && sr_wr_en) begin
            flags = sr_wr_data;
        end
        pass_next = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            pass_next[i] = cond_eval(cond[4*i +: 4], flags);
        end
    end

    // Ready is held low during reset so nothing is accepted into a stage being cleared.
    assign cond_ready = ~rst & (~pass_valid_q | pass_ready);
    assign accept     = cond_valid & cond_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q     <= 4'b0000;
            pass_valid_q <= 1'b0;
            pass_q       <= '0;
        end else begin
            if (sr_wr_en) begin
                status_q <= sr_wr_data;
            end
            if (accept) begin
                pass_q       <= pass_next;
                pass_valid_q <= 1'b1;
            end else if (pass_ready) begin
                pass_valid_q <= 1'b0;
            end
        end
    end

    assign status     = status_q;
    assign pass_valid = pass_valid_q;
    assign pass       = pass_q;

`ifdef COND_STATS_EN
    function automatic logic [3:0] popcount(input logic [LANES-1:0] vec);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            cnt = cnt + 4'(vec[i]);
        end
        return cnt;
    endfunction

    logic [15:0] pass_cnt_q;
    logic [15:0] fail_cnt_q;
    logic [3:0]  pass_inc;
    logic [3:0]  fail_inc;
    logic [16:0] pass_sum;
    logic [16:0] fail_sum;

    always_comb begin
        pass_inc = popcount(pass_next);
        fail_inc = 4'(LANES) - pass_inc;
        pass_sum = {1'b0, pass_cnt_q} + 17'(pass_inc);
        fail_sum = {1'b0, fail_cnt_q} + 17'(fail_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (accept) begin
            // Carry out of bit 15 means the count would wrap; pin at all-ones instead.
            pass_cnt_q <= pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
            fail_cnt_q <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_cond_status_unit.sv
// Self-checking bench for cond_status_unit (LANES=2). A bypassing instance is the main
// device; a non-bypassing instance shares its inputs for the same-cycle write case.

`timescale 1ns / 1ps

module tb_cond_status_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sr_wr_en = 1'b0;
    logic [3:0] sr_wr_data = 4'b0000;
    logic       cond_valid = 1'b0;
    logic [7:0] cond = 8'h00;
    logic       pass_ready = 1'b1;

    logic       cond_ready, pass_valid;
    logic [1:0] pass;
    logic [3:0] status;
    logic       nb_cond_ready, nb_pass_valid;
    logic [1:0] nb_pass;
    logic [3:0] nb_status;
`ifdef COND_STATS_EN
    logic [15:0] pass_cnt, fail_cnt, nb_pass_cnt, nb_fail_cnt;
`endif

    always #5 clk = ~clk;

    cond_status_unit #(.LANES(2), .BYPASS(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sr_wr_en   (sr_wr_en),
        .sr_wr_data (sr_wr_data),
        .cond_valid (cond_valid),
        .cond       (cond),
        .cond_ready (cond_ready),
        .pass_valid (pass_valid),
        .pass       (pass),
        .pass_ready (pass_ready),
        .status     (status)
`ifdef COND_STATS_EN
        ,
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt)
`endif
    );

    cond_status_unit #(.LANES(2), .BYPASS(0)) u_dut_nb (
        .clk        (clk),
        .rst        (rst),
        .sr_wr_en   (sr_wr_en),
        .sr_wr_data (sr_wr_data),
        .cond_valid (cond_valid),
        .cond       (cond),
        .cond_ready (nb_cond_ready),
        .pass_valid (nb_pass_valid),
        .pass       (nb_pass),
        .pass_ready (pass_ready),
        .status     (nb_status)
`ifdef COND_STATS_EN
        ,
        .pass_cnt   (nb_pass_cnt),
        .fail_cnt   (nb_fail_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected pass words, pushed at the accept, popped at delivery.
    logic [1:0] exp_q[$];
    logic [1:0] cur_exp = 2'b00;
    logic [3:0] status_m = 4'b0000;

    always @(negedge clk) begin
        logic [1:0] e;
        check("status", {28'd0, status}, {28'd0, status_m});
        if (rst) begin
            check("rst_cond_ready", {31'd0, cond_ready}, 32'd0);
            exp_q.delete();
            status_m = 4'b0000;
        end else begin
            check("pass_valid_vs_sb", {31'd0, pass_valid}, {31'd0, exp_q.size() != 0});
            if (pass_valid && pass_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_delivery", {30'd0, pass}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pass", {30'd0, pass}, {30'd0, e});
                    n_pop++;
                end
            end
            if (cond_valid && cond_ready) exp_q.push_back(cur_exp);
            if (sr_wr_en) status_m = sr_wr_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c1, input logic [3:0] c0, input logic wr,
                        input logic [3:0] wd, input logic [1:0] exp);
        cond_valid = 1'b1;
        cond       = {c1, c0};
        sr_wr_en   = wr;
        sr_wr_data = wd;
        cur_exp    = exp;
        step();
        cond_valid = 1'b0;
        sr_wr_en   = 1'b0;
    endtask

    typedef struct {
        logic [3:0] flags;  // {N,Z,C,V}
        logic [3:0] c1;
        logic [3:0] c0;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int p0;
        vecs[0]  = '{4'b0100, 4'b0001, 4'b0000, 2'b01};
        vecs[1]  = '{4'b0000, 4'b0001, 4'b0000, 2'b10};
        vecs[2]  = '{4'b0010, 4'b0011, 4'b0010, 2'b01};
        vecs[3]  = '{4'b0000, 4'b0011, 4'b0010, 2'b10};
        vecs[4]  = '{4'b1000, 4'b0101, 4'b0100, 2'b01};
        vecs[5]  = '{4'b0001, 4'b0111, 4'b0110, 2'b01};
        vecs[6]  = '{4'b0000, 4'b0111, 4'b0110, 2'b10};
        vecs[7]  = '{4'b0010, 4'b1001, 4'b1000, 2'b01};
        vecs[8]  = '{4'b0110, 4'b1001, 4'b1000, 2'b10};
        vecs[9]  = '{4'b0000, 4'b1001, 4'b1000, 2'b10};
        vecs[10] = '{4'b1001, 4'b1011, 4'b1010, 2'b01};
        vecs[11] = '{4'b1000, 4'b1011, 4'b1010, 2'b10};
        vecs[12] = '{4'b0000, 4'b1101, 4'b1100, 2'b01};
        vecs[13] = '{4'b1000, 4'b1101, 4'b1100, 2'b10};
        vecs[14] = '{4'b0100, 4'b1101, 4'b1100, 2'b10};
        vecs[15] = '{4'b1101, 4'b1101, 4'b1100, 2'b10};
        vecs[16] = '{4'b1111, 4'b1111, 4'b1110, 2'b01};
        vecs[17] = '{4'b0000, 4'b1110, 4'b1110, 2'b11};
        vecs[18] = '{4'b0101, 4'b0000, 4'b0111, 2'b10};
        vecs[19] = '{4'b1011, 4'b1000, 4'b1100, 2'b11};

        // Reset state
        repeat (2) step();
        @(negedge clk); #1;
        check("reset_pass_valid", {31'd0, pass_valid}, 32'd0);
        check("reset_pass", {30'd0, pass}, 32'd0);
        check("reset_status", {28'd0, status}, 32'd0);
        check("reset_cond_ready", {31'd0, cond_ready}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk); #1;
        check("ready_after_release", {31'd0, cond_ready}, 32'd1);
`ifdef COND_STATS_EN
        check("reset_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        check("reset_fail_cnt", {16'd0, fail_cnt}, 32'd0);
`endif
        step();

        // N flag set, lane0 = N, lane1 = !N
        sr_wr_en = 1'b1; sr_wr_data = 4'b1000;
        step();
        sr_wr_en = 1'b0;
        send(4'b0101, 4'b0100, 1'b0, 4'b0000, 2'b01);
        @(negedge clk); #1;
        check("n_flag_status", {28'd0, status}, 32'h8);
        step();

        // Same-cycle write: bypass sees Z=1, non-bypass sees old status 0000
        sr_wr_en = 1'b1; sr_wr_data = 4'b0000;
        step();
        send(4'b1110, 4'b0000, 1'b1, 4'b0100, 2'b11);
        @(negedge clk); #1;
        check("nobypass_valid", {31'd0, nb_pass_valid}, 32'd1);
        check("nobypass_pass", {30'd0, nb_pass}, 32'h2);
        step();

        // Stall: held word stays put while status is rewritten; exactly one beat drains
        pass_ready = 1'b0;
        send(4'b0000, 4'b0001, 1'b1, 4'b0000, 2'b01);
        for (int k = 0; k < 3; k++) begin
            cond_valid = 1'b1; cond = 8'hEE; cur_exp = 2'b11;
            sr_wr_en = 1'b1; sr_wr_data = 4'b0100;
            @(negedge clk); #1;
            check("stall_cond_ready", {31'd0, cond_ready}, 32'd0);
            check("stall_pass_valid", {31'd0, pass_valid}, 32'd1);
            check("stall_pass", {30'd0, pass}, 32'h1);
            step();
        end
        cond_valid = 1'b0; sr_wr_en = 1'b0;
        p0 = n_pop;
        pass_ready = 1'b1;
        step();
        @(negedge clk); #1;
        check("stall_one_beat", n_pop - p0, 32'd1);
        check("stall_drained", {31'd0, pass_valid}, 32'd0);
        step();

        // 20-word back-to-back stream, flags written with each word
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            cond_valid = 1'b1;
            cond       = {vecs[i].c1, vecs[i].c0};
            sr_wr_en   = 1'b1;
            sr_wr_data = vecs[i].flags;
            cur_exp    = vecs[i].exp;
            @(negedge clk); #1;
            check("stream_cond_ready", {31'd0, cond_ready}, 32'd1);
            step();
        end
        cond_valid = 1'b0; sr_wr_en = 1'b0;
        step();
        check("stream_consecutive", n_pop - p0, 32'd20);

        // Reset during a stall discards the held word
        pass_ready = 1'b0;
        send(4'b0000, 4'b1110, 1'b0, 4'b0000, 2'b11);
        sr_wr_en = 1'b1; sr_wr_data = 4'b1111;
        step();
        sr_wr_en = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        check("midstall_rst_ready", {31'd0, cond_ready}, 32'd0);
        step();
        rst = 1'b0;
        pass_ready = 1'b1;
        @(negedge clk); #1;
        check("midstall_rst_valid", {31'd0, pass_valid}, 32'd0);
        check("midstall_rst_status", {28'd0, status}, 32'd0);
        check("midstall_rst_ready_after", {31'd0, cond_ready}, 32'd1);
        p0 = n_pop;
        repeat (3) step();
        check("held_word_dropped", n_pop - p0, 32'd0);

`ifdef COND_STATS_EN
        // Two passing lanes per accept: 32767 accepts reach FFFE, the next one saturates
        rst = 1'b1;
        step();
        rst = 1'b0;
        cond_valid = 1'b1; cond = 8'hEE; cur_exp = 2'b11;
        repeat (32767) step();
        check("pass_cnt_below_sat", {16'd0, pass_cnt}, 32'hFFFE);
        check("fail_cnt_zero", {16'd0, fail_cnt}, 32'd0);
        repeat (300) step();
        check("pass_cnt_saturated", {16'd0, pass_cnt}, 32'hFFFF);
        cond = 8'hFF; cur_exp = 2'b00;
        repeat (33000) step();
        cond_valid = 1'b0;
        check("pass_cnt_held", {16'd0, pass_cnt}, 32'hFFFF);
        check("fail_cnt_saturated", {16'd0, fail_cnt}, 32'hFFFF);
        step();
`endif

        repeat (2) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
